// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: operation ids (same numbering
// the controller decodes), MIPS opcode/funct fields, encoder states and word builders.
package instr_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_NOR   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_JR    = 5'd11;
    localparam logic [4:0] OP_NOP   = 5'd12;
    localparam logic [4:0] OP_ANDI  = 5'd13;
    localparam logic [4:0] OP_ORI   = 5'd14;
    localparam logic [4:0] OP_SLTI  = 5'd15;
    localparam logic [4:0] OP_ADDI  = 5'd16;
    localparam logic [4:0] OP_ADDIU = 5'd17;
    localparam logic [4:0] OP_LW    = 5'd18;
    localparam logic [4:0] OP_SW    = 5'd19;
    localparam logic [4:0] OP_LUI   = 5'd20;
    localparam logic [4:0] OP_BEQ   = 5'd21;
    localparam logic [4:0] OP_BNE   = 5'd22;
    localparam logic [4:0] OP_BGTZ  = 5'd23;
    localparam logic [4:0] OP_BGEZ  = 5'd24;
    localparam logic [4:0] OP_J     = 5'd25;
    localparam logic [4:0] OP_JAL   = 5'd26;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_BNE     = 6'b000101;
    localparam logic [5:0] OPC_BGTZ    = 6'b000111;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_ADDIU   = 6'b001001;
    localparam logic [5:0] OPC_SLTI    = 6'b001010;
    localparam logic [5:0] OPC_ANDI    = 6'b001100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        NOP_INS = 2'd1,
        FULL    = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0]  op_id;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_req_t;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OPC_SPECIAL, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake, instruction-memory write port and status bundle of the encoder.
// The source/boot program drives the master side; the encoder is the slave.
interface instr_encoder_if #(parameter int ADDR_W = 8);

    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_id;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imem_wen;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
    logic              err_clr;

    modport master (
        output in_valid, op_id, rs, rt, rd, shamt, imm, target, err_clr,
        input  in_ready, imem_wen, imem_addr, imem_data, count, full, err
    );

    modport slave (
        input  in_valid, op_id, rs, rt, rd, shamt, imm, target, err_clr,
        output in_ready, imem_wen, imem_addr, imem_data, count, full, err
    );

endinterface

// File: rtl/instr_word_enc.sv
// Combinational encoder: abstract request -> 32-bit MIPS word plus illegal and
// branch/jump classification. Field forcing (shamt, rs, rt) happens here.
module instr_word_enc
    import instr_pkg::*;
(
    input  instr_req_t  req_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        is_branch_o
);

    // NOTE: every output gets a default before the case, so no path can infer a latch.
    always_comb begin
        word_o      = '0;
        illegal_o   = 1'b0;
        is_branch_o = 1'b0;
        case (req_i.op_id)
            OP_ADD:   word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_ADD);
            OP_ADDU:  word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_ADDU);
            OP_SUB:   word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_SUB);
            OP_SUBU:  word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_SUBU);
            OP_AND:   word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_AND);
            OP_OR:    word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_OR);
            OP_NOR:   word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_NOR);
            OP_SLT:   word_o = rtype(req_i.rs, req_i.rt, req_i.rd, 5'd0, FN_SLT);
            OP_SLL:   word_o = rtype(5'd0, req_i.rt, req_i.rd, req_i.shamt, FN_SLL);
            OP_SRL:   word_o = rtype(5'd0, req_i.rt, req_i.rd, req_i.shamt, FN_SRL);
            OP_SRA:   word_o = rtype(5'd0, req_i.rt, req_i.rd, req_i.shamt, FN_SRA);
            OP_JR: begin
                word_o      = rtype(req_i.rs, 5'd0, 5'd0, 5'd0, FN_JR);
                is_branch_o = 1'b1;
            end
            OP_NOP:   word_o = '0;
            OP_ANDI:  word_o = itype(OPC_ANDI,  req_i.rs, req_i.rt, req_i.imm);
            OP_ORI:   word_o = itype(OPC_ORI,   req_i.rs, req_i.rt, req_i.imm);
            OP_SLTI:  word_o = itype(OPC_SLTI,  req_i.rs, req_i.rt, req_i.imm);
            OP_ADDI:  word_o = itype(OPC_ADDI,  req_i.rs, req_i.rt, req_i.imm);
            OP_ADDIU: word_o = itype(OPC_ADDIU, req_i.rs, req_i.rt, req_i.imm);
            OP_LW:    word_o = itype(OPC_LW,    req_i.rs, req_i.rt, req_i.imm);
            OP_SW:    word_o = itype(OPC_SW,    req_i.rs, req_i.rt, req_i.imm);
            OP_LUI:   word_o = itype(OPC_LUI,   5'd0,     req_i.rt, req_i.imm);
            OP_BEQ: begin
                word_o      = itype(OPC_BEQ, req_i.rs, req_i.rt, req_i.imm);
                is_branch_o = 1'b1;
            end
            OP_BNE: begin
                word_o      = itype(OPC_BNE, req_i.rs, req_i.rt, req_i.imm);
                is_branch_o = 1'b1;
            end
            OP_BGTZ: begin
                word_o      = itype(OPC_BGTZ, req_i.rs, 5'd0, req_i.imm);
                is_branch_o = 1'b1;
            end
            // bgez shares the REGIMM opcode; rt=1 selects it
            OP_BGEZ: begin
                word_o      = itype(OPC_REGIMM, req_i.rs, 5'd1, req_i.imm);
                is_branch_o = 1'b1;
            end
            OP_J: begin
                word_o      = {OPC_J, req_i.target};
                is_branch_o = 1'b1;
            end
            OP_JAL: begin
                word_o      = {OPC_JAL, req_i.target};
                is_branch_o = 1'b1;
            end
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder / imem loader: handshake, state machine, address counter, output regs.
// Optional BRANCH_DELAY_NOP_EN: write a NOP after every branch/jump as its delay slot.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);

`ifdef BRANCH_DELAY_NOP_EN
    localparam bit NOP_EN = 1'b1;
`else
    localparam bit NOP_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    instr_req_t  req;
    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        enc_branch;
    logic        accept;
    logic        at_cap;

    assign req = '{op_id: bus.op_id, rs: bus.rs, rt: bus.rt, rd: bus.rd,
                   shamt: bus.shamt, imm: bus.imm, target: bus.target};

    instr_word_enc u_enc (
        .req_i       (req),
        .word_o      (enc_word),
        .illegal_o   (enc_illegal),
        .is_branch_o (enc_branch)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign at_cap = (count_q == CAPACITY);

    always_comb begin
        state_d = state_q;
        wen_d   = 1'b0;
        data_d  = data_q;
        count_d = count_q;
        // The register always trails the counter: the written address during a
        // write, the next free address otherwise (wrapping to 0 once full).
        addr_d  = count_q[ADDR_W-1:0];
        // A fresh illegal op outranks a simultaneous clear
        err_d   = (err_q && !bus.err_clr) || (accept && enc_illegal);
        unique case (state_q)
            ACCEPT: begin
                if (at_cap) begin
                    state_d = FULL;
                end else if (accept && !enc_illegal) begin
                    wen_d   = 1'b1;
                    data_d  = enc_word;
                    count_d = count_q + 1'b1;
                    if (NOP_EN && enc_branch) begin
                        state_d = NOP_INS;
                    end
                end
            end
            NOP_INS: begin
                if (at_cap) begin
                    state_d = FULL;
                end else begin
                    wen_d   = 1'b1;
                    data_d  = '0;
                    count_d = count_q + 1'b1;
                    state_d = ACCEPT;
                end
            end
            FULL:    state_d = FULL;
            default: state_d = ACCEPT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCEPT;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign bus.full      = (state_q == FULL);
    assign bus.in_ready  = (state_q == ACCEPT) && !bus.full;
    assign bus.imem_wen  = wen_q;
    assign bus.imem_addr = addr_q;
    assign bus.imem_data = data_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;

endmodule
